// File: rtl/seg_display_mux_if.sv
// Load-side bus between the result register and the display controller.
interface seg_display_mux_if #(
  parameter int DATA_W = 32
) ();
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        mode_in;
  logic              blank_lz;
  logic              busy;

  modport master (output load, data_in, mode_in, blank_lz, input busy);
  modport slave  (input load, data_in, mode_in, blank_lz, output busy);
endinterface

// File: rtl/seg_display_mux.sv
// Scanned 7-seg controller: hex loads commit next edge; decimal loads take DATA_W+1 cycles.
// While busy, further loads are dropped; the panel keeps the old buffer until commit.
module seg_display_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int DATA_W       = 32,
  parameter int REFRESH_BITS = 17,
  parameter int FRAC_DIGIT   = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_mux_if.slave      i_ctl,
  output logic [7:0]            o_seg,
  output logic [NUM_DIGITS-1:0] o_an
);
  localparam int BCD_DIGITS = ((DATA_W * 1233) >> 12) + 1;
  localparam int BCD_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W      = $clog2(DATA_W);
  localparam int NIB_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t r_state, w_state_nxt;

  logic [REFRESH_BITS-1:0] r_presc;
  logic [DIG_W-1:0]        r_dig;
  logic [NIB_W-1:0]        r_buf_nib;
  logic [1:0]              r_buf_mode;
  logic                    r_buf_blank, r_buf_neg, r_buf_ovf;

  logic [DATA_W-1:0]       r_bin;
  logic [4*BCD_N-1:0]      r_bcd;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_mode;
  logic                    r_blank, r_neg;

  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_load_ok, w_load_dec, w_last, w_neg_in, w_ovf, w_upper_nz;
  logic [DATA_W-1:0]       w_mag;
  logic [NIB_W-1:0]        w_data_ext;
  logic [4*BCD_N-1:0]      w_bcd_adj;
  logic [3:0]              w_nib;
  logic [7:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;

  function automatic logic [6:0] f_hex7(input logic [3:0] n);
    case (n)
      4'h0: f_hex7 = 7'h3F;  4'h1: f_hex7 = 7'h06;  4'h2: f_hex7 = 7'h5B;  4'h3: f_hex7 = 7'h4F;
      4'h4: f_hex7 = 7'h66;  4'h5: f_hex7 = 7'h6D;  4'h6: f_hex7 = 7'h7D;  4'h7: f_hex7 = 7'h07;
      4'h8: f_hex7 = 7'h7F;  4'h9: f_hex7 = 7'h6F;  4'hA: f_hex7 = 7'h77;  4'hB: f_hex7 = 7'h7C;
      4'hC: f_hex7 = 7'h39;  4'hD: f_hex7 = 7'h5E;  4'hE: f_hex7 = 7'h79;  default: f_hex7 = 7'h71;
    endcase
  endfunction

  assign w_load_ok  = i_ctl.load && (r_state == S_IDLE);
  assign w_load_dec = w_load_ok && i_ctl.mode_in[1];
  assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_neg_in   = (i_ctl.mode_in == 2'b11) && i_ctl.data_in[DATA_W-1];
  assign w_mag      = w_neg_in ? (-i_ctl.data_in) : i_ctl.data_in;
  assign i_ctl.busy = (r_state != S_IDLE);
  assign o_seg      = r_seg;
  assign o_an       = r_an;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_load_dec) w_state_nxt = S_CONV;
      S_CONV:   if (w_last) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_data_ext = '0;
    w_data_ext[DATA_W-1:0] = i_ctl.data_in;
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Negative results give up the top digit to the sign, so the limit drops by one.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < BCD_N; i++) begin
      if ((i >= (r_neg ? NUM_DIGITS - 1 : NUM_DIGITS)) && (r_bcd[4*i +: 4] != 4'd0)) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_mode  <= 2'b00;
      r_blank <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_load_dec) begin
      r_bin   <= w_mag;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_mode  <= i_ctl.mode_in;
      r_blank <= i_ctl.blank_lz;
      r_neg   <= w_neg_in;
    end else if (r_state == S_CONV) begin
      r_bcd <= {w_bcd_adj[4*BCD_N-2:0], r_bin[DATA_W-1]};
      r_bin <= {r_bin[DATA_W-2:0], 1'b0};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_nib   <= '0;
      r_buf_mode  <= 2'b00;
      r_buf_blank <= 1'b0;
      r_buf_neg   <= 1'b0;
      r_buf_ovf   <= 1'b0;
    end else if (w_load_ok && !i_ctl.mode_in[1]) begin
      r_buf_nib   <= w_data_ext;
      r_buf_mode  <= i_ctl.mode_in;
      r_buf_blank <= i_ctl.blank_lz;
      r_buf_neg   <= 1'b0;
      r_buf_ovf   <= 1'b0;
    end else if (r_state == S_COMMIT) begin
      r_buf_nib   <= r_bcd[NIB_W-1:0];
      r_buf_mode  <= r_mode;
      r_buf_blank <= r_blank;
      r_buf_neg   <= r_neg;
      r_buf_ovf   <= w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_dig   <= '0;
    end else begin
      r_presc <= r_presc + REFRESH_BITS'(1);
      if (&r_presc) r_dig <= (r_dig == DIG_W'(NUM_DIGITS - 1)) ? '0 : r_dig + DIG_W'(1);
    end
  end

  always_comb begin
    w_nib      = r_buf_nib[4*r_dig +: 4];
    w_upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(r_dig)) && (r_buf_nib[4*j +: 4] != 4'd0)) w_upper_nz = 1'b1;
    end
    w_seg = {1'b0, f_hex7(w_nib)};
    if (r_buf_ovf)
      w_seg = 8'h40;
    else if (r_buf_neg && (int'(r_dig) == NUM_DIGITS - 1))
      w_seg = 8'h40;
    else if (!r_buf_mode[1] && (4 * int'(r_dig) >= DATA_W))
      w_seg = 8'h00;
    else if (r_buf_blank && !w_upper_nz && (r_dig != '0) &&
             !((r_buf_mode == 2'b01) && (int'(r_dig) <= FRAC_DIGIT)))
      w_seg = 8'h00;
    if ((r_buf_mode == 2'b01) && (int'(r_dig) == FRAC_DIGIT)) w_seg[7] = 1'b1;
    w_an = NUM_DIGITS'(1) << r_dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= ACTIVE_LOW ? 8'hFF : 8'h00;
      r_an  <= ACTIVE_LOW ? '1 : '0;
    end else begin
      r_seg <= ACTIVE_LOW ? ~w_seg : w_seg;
      r_an  <= ACTIVE_LOW ? ~w_an : w_an;
    end
  end
endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: expected digit patterns queued per load, popped per scanned digit.
module tb_seg_display_mux;
  logic       clk;
  logic       rst;
  logic [7:0] seg;
  logic [7:0] an;
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] sb_seg[$];

  seg_display_mux_if #(.DATA_W(32)) u_if ();

  seg_display_mux #(
    .NUM_DIGITS  (8),
    .DATA_W      (32),
    .REFRESH_BITS(2),
    .FRAC_DIGIT  (4),
    .ACTIVE_LOW  (1'b1)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .i_ctl(u_if),
    .o_seg(seg),
    .o_an (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [6:0] char_seg(input byte c);
    case (c)
      "0": return 7'h3F;  "1": return 7'h06;  "2": return 7'h5B;  "3": return 7'h4F;
      "4": return 7'h66;  "5": return 7'h6D;  "6": return 7'h7D;  "7": return 7'h07;
      "8": return 7'h7F;  "9": return 7'h6F;  "A": return 7'h77;  "B": return 7'h7C;
      "C": return 7'h39;  "D": return 7'h5E;  "E": return 7'h79;  "F": return 7'h71;
      "-": return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  // Text is written most significant digit first, as it reads on the panel.
  function automatic logic [7:0] exp_seg(input string s, input int dotd, input int d);
    logic dp;
    dp = (d == dotd);
    return ~{dp, char_seg(s[7-d])};
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  task automatic push_frame(input string s, input int dotd);
    for (int d = 0; d < 8; d++) sb_seg.push_back(exp_seg(s, dotd, d));
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] exp;
    for (int d = 0; d < 8; d++) begin
      int n;
      n = 0;
      while (an !== an_of(d) && n < 200) begin
        @(negedge clk);
        n++;
      end
      exp = sb_seg.pop_front();
      chk({tag, "_an"}, {24'h0, an}, {24'h0, an_of(d)});
      chk({tag, "_seg"}, {24'h0, seg}, {24'h0, exp});
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [1:0] m, input logic b);
    u_if.data_in  = v;
    u_if.mode_in  = m;
    u_if.blank_lz = b;
    u_if.load     = 1'b1;
    @(negedge clk);
    u_if.load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (u_if.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, u_if.busy}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    u_if.load = 1'b0;
    u_if.data_in = '0;
    u_if.mode_in = 2'b00;
    u_if.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_an", {24'h0, an}, 32'hFF);
    chk("rst_busy", {31'h0, u_if.busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("scan_start_an", {24'h0, an}, 32'hFE);
    chk("scan_start_seg", {24'h0, seg}, 32'hC0);

    // Plain hex, and the 4-cycle dwell per digit.
    do_load(32'h1234ABCD, 2'b00, 1'b0);
    chk("hex_busy", {31'h0, u_if.busy}, 32'h0);
    @(negedge clk);
    push_frame("1234ABCD", -1);
    check_frame("hex");
    n = 0;
    while (an !== an_of(1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (an === an_of(1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dwell", n, 4);

    // Q format with blanking; dot on digit 4.
    do_load(32'h00018000, 2'b01, 1'b1);
    @(negedge clk);
    push_frame("   18000", 4);
    check_frame("qhex");

    // Unsigned decimal: busy length and old value held during conversion.
    do_load(32'd12345678, 2'b10, 1'b0);
    n = 0;
    while (u_if.busy && n < 100) begin
      for (int d = 0; d < 8; d++) begin
        if (an === an_of(d)) chk("hold", {24'h0, seg}, {24'h0, exp_seg("   18000", 4, d)});
      end
      @(negedge clk);
      n++;
    end
    chk("busy_len", n, 33);
    @(negedge clk);
    push_frame("12345678", -1);
    check_frame("udec");

    do_load(32'hFFFFFF85, 2'b11, 1'b1);
    wait_idle("sdec_done");
    push_frame("-    123", -1);
    check_frame("sdec");

    do_load(32'd100000000, 2'b10, 1'b0);
    wait_idle("uovf_done");
    push_frame("--------", -1);
    check_frame("uovf");

    do_load(-32'sd10000000, 2'b11, 1'b0);
    wait_idle("sovf_done");
    push_frame("--------", -1);
    check_frame("sovf");

    do_load(32'd0, 2'b10, 1'b1);
    wait_idle("zero_done");
    push_frame("       0", -1);
    check_frame("zero");

    // A load while converting is dropped; the first result still commits.
    do_load(32'd42, 2'b10, 1'b0);
    repeat (4) @(negedge clk);
    do_load(32'h99, 2'b00, 1'b0);
    chk("ign_busy", {31'h0, u_if.busy}, 32'h1);
    wait_idle("ign_done");
    push_frame("00000042", -1);
    check_frame("ignore");

    // Reset mid-conversion.
    do_load(32'd777, 2'b10, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'h0, u_if.busy}, 32'h0);
    chk("abort_an", {24'h0, an}, 32'hFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push_frame("00000000", -1);
    check_frame("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
